// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus ports: default frame width and the
// receive FSM state encoding. Unused state codes are treated as IDLE.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 8;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t RX_IDLE = 2'b00;
  localparam rx_state_t RX_RECV = 2'b01;

endpackage

// File: rtl/rx_byte_fifo.sv
// Small completed-byte buffer for the master receive port. Synchronous
// push/pop, head-of-queue read, pointers wrap modulo FIFO_DEPTH.
module rx_byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2,
  localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  // Popping an empty FIFO is ignored; a push into a full FIFO only lands if
  // the head is leaving on the same edge.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/master_in_port.sv
// Master-side serial receive port. Accepts an LSB-first bit stream from the
// slave output port, rebuilds each byte, buffers it, and offers it to the
// master core over a valid/ack handshake. Malformed frames pulse frame_err.
module master_in_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slave_data_ready,
  input  logic                  rx_data,
  input  logic                  rx_done,
  output logic                  master_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ack,
  output logic                  rx_busy,
  output logic                  frame_err
);

  localparam int            CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int            FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  // Only bits 0..DATA_WIDTH-2 are stored; the last bit goes straight into the push word.
  logic [DATA_WIDTH-2:0] r_shift;
  logic                  r_master_ready;
  logic                  r_frame_err;

  logic                  w_handshake;
  logic                  w_last;
  logic                  w_push;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_pop;
  logic [FCW-1:0]        w_count;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_space;
  logic [CNT_W-2:0]      w_idx;

  assign w_handshake = (r_state == RX_IDLE) & r_master_ready & slave_data_ready;
  assign w_last      = (r_bit_cnt == LAST);
  assign w_idx       = r_bit_cnt[CNT_W-2:0];
  assign w_push      = (r_state == RX_RECV) & rx_done & w_last;
  assign w_push_data = {rx_data, r_shift};
  assign w_pop       = dout_ack & ~w_empty;
  assign w_space     = (w_count < FCW'(FIFO_DEPTH));

  rx_byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // Receive FSM with bit counter, shift register and registered ready/err.
  // Ready only rises from IDLE, so the FIFO slot is reserved before a frame starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RX_IDLE;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_master_ready <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (w_handshake) begin
            r_state        <= RX_RECV;
            r_bit_cnt      <= '0;
            r_master_ready <= 1'b0;
          end else begin
            r_master_ready <= w_space;
          end
        end
        RX_RECV: begin
          r_master_ready <= 1'b0;
          r_bit_cnt      <= r_bit_cnt + CNT_W'(1);
          if (!w_last) r_shift[w_idx] <= rx_data;
          if (rx_done || w_last) begin
            // Good frame pushes combinationally on this edge; anything else is dropped.
            r_state     <= RX_IDLE;
            r_bit_cnt   <= '0;
            r_frame_err <= ~(rx_done & w_last);
          end
        end
        default: begin
          r_state        <= RX_IDLE;
          r_bit_cnt      <= '0;
          r_master_ready <= 1'b0;
        end
      endcase
    end
  end

  assign master_ready = r_master_ready;
  assign frame_err    = r_frame_err;
  assign rx_busy      = (r_state == RX_RECV);
  assign dout_valid   = ~w_empty;
  assign dout         = w_head;

endmodule
